// File: rtl/obsm_if.sv
// Output-port side of the request/ack switch protocol.
// Handshake: an input port raises req[i] to ask for this output; the output
// answers with a one-hot ack[i]. While ack[i] is high, the flit on pkti[i]
// is consumed on every rising edge, including 00 bubbles. The grant is
// withdrawn on the edge that consumes a tail flit (type 11). req is only
// looked at while no grant is active, so dropping it early is harmless.
interface obsm_if;
  logic [3:0]  req;
  logic [39:0] pkti;
  logic [3:0]  ack;
  logic [9:0]  pkto;

  modport master (output req, output pkti, input ack, input pkto);
  modport slave  (input req, input pkti, output ack, output pkto);
endinterface

// File: rtl/obsm.sv
// Output buffer state machine: round-robin grant of one of four input
// ports, then forwarding of that port's flits to the output link until the
// tail flit has gone through, followed by a one-cycle release gap.
module obsm (
  input  logic       clk,
  input  logic       rst,
  obsm_if.slave      bus,
  output logic [1:0] dbg_state
);
  localparam int PKTW = 9;
  localparam int PORT = 3;
  localparam int FW   = PKTW + 1;
  localparam int NP   = PORT + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [1:0]      last, last_n;
  logic [1:0]      win;
  logic            win_vld;
  logic [NP-1:0]   ack_q, ack_n;
  logic [FW-1:0]   pkto_q, pkto_n;
  logic [FW-1:0]   cur;

  // Round-robin pick: first requester after the most recent winner.
  always_comb begin
    win     = last;
    win_vld = 1'b0;
    for (int k = 1; k <= NP; k++) begin
      if (!win_vld && bus.req[2'(last + 2'(k))]) begin
        win     = 2'(last + 2'(k));
        win_vld = 1'b1;
      end
    end
  end

  // While granted, `last` is the owner, so its lane is the forwarded one.
  assign cur = bus.pkti[int'(last) * FW +: FW];

  // Next-state, grant and output flit selection.
  always_comb begin
    state_n = state;
    last_n  = last;
    ack_n   = ack_q;
    pkto_n  = '0;
    case (state)
      IDLE: begin
        ack_n = '0;
        if (win_vld) begin
          state_n = BUSY;
          ack_n   = 4'b0001 << win;
          last_n  = win;
        end
      end
      BUSY: begin
        pkto_n = cur;
        if (cur[FW-1:FW-2] == 2'b11) begin
          ack_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        ack_n   = '0;
        state_n = IDLE;
      end
      default: begin
        ack_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs; reset clears any grant in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 2'd3;
      ack_q  <= '0;
      pkto_q <= '0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      ack_q  <= ack_n;
      pkto_q <= pkto_n;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.pkto  = pkto_q;
  assign dbg_state = state;
endmodule
